// File: rtl/ila_capture_seq.sv
// ila_capture_seq: sequences one ILA capture run and streams the captured buffer.
//   A start pulse soft-clears the ILA, arms it until a sample target, a full
//   buffer or a timeout is reached, then reads every stored sample (N_PARTS
//   words each) out on a valid/ready stream.
// Ports
//   clk_i, arst_n_i, cke_i      clock, async active-low reset, clock enable
//   start_i, abort_i            run control pulses
//   cfg_misc_i, target_i,       run configuration
//   timeout_i
//   ila_misc_o, ila_samples_i,  ILA control / status / read port
//   ila_index_o, ila_sel_o,
//   ila_value_i
//   m_valid_o, m_ready_i,       readout stream
//   m_data_o, m_last_o
//   busy_o, done_o, timeout_o,  run status
//   nsamples_o
module ila_capture_seq #(
  parameter int DATA_W   = 32,
  parameter int BUFFER_W = 10,
  parameter int N_PARTS  = 1,
  parameter int SEL_W    = 1,
  parameter int RD_LAT   = 2,
  parameter int CLR_CYC  = 4
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [31:0]         cfg_misc_i,
  input  logic [BUFFER_W-1:0] target_i,
  input  logic [31:0]         timeout_i,
  output logic [31:0]         ila_misc_o,
  input  logic [BUFFER_W-1:0] ila_samples_i,
  output logic [BUFFER_W-1:0] ila_index_o,
  output logic [SEL_W-1:0]    ila_sel_o,
  input  logic [DATA_W-1:0]   ila_value_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [DATA_W-1:0]   m_data_o,
  output logic                m_last_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [BUFFER_W-1:0] nsamples_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ARM, S_READ, S_PUSH, S_DONE
  } state_t;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_PARTS - 1);
  localparam logic [31:0]      CLR_END  = 32'(CLR_CYC - 1);
  // The ILA read port is RD_LAT registers deep, so the word for an index set
  // on entry to READ is first sampleable on the (RD_LAT+1)-th READ edge.
  localparam logic [31:0]      LAT_END  = 32'(RD_LAT);

  state_t              r_state, w_next;
  logic [31:0]         r_cnt;   // CLEAR length / READ latency counter
  logic [31:0]         r_arm;   // cycles already spent in ARM
  logic [BUFFER_W-1:0] r_idx, r_ns;
  logic [SEL_W-1:0]    r_sel;
  logic [DATA_W-1:0]   r_data;
  logic                r_last, r_tmo;

  logic w_smp_hit, w_tmo_hit, w_word_last;

  assign w_smp_hit = ((target_i != '0) && (ila_samples_i >= target_i)) || (&ila_samples_i);
  assign w_tmo_hit = (timeout_i != '0) && ((r_arm + 32'd1) == timeout_i);
  assign w_word_last = (r_idx == (r_ns - BUFFER_W'(1))) && (r_sel == SEL_LAST);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  r_state <= S_IDLE;
    else if (cke_i) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_CLEAR;
      S_CLEAR: if (r_cnt == CLR_END) w_next = S_ARM;
      S_ARM:   if (w_smp_hit || w_tmo_hit)
                 w_next = (ila_samples_i == '0) ? S_DONE : S_READ;
      S_READ:  if (r_cnt == LAT_END) w_next = S_PUSH;
      S_PUSH:  if (m_ready_i) w_next = r_last ? S_DONE : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // abort overrides everything, including a handshake in the same cycle
    if (abort_i && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // Datapath updates key off w_next so an abort suppresses every side effect.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_cnt  <= '0;
      r_arm  <= '0;
      r_idx  <= '0;
      r_sel  <= '0;
      r_ns   <= '0;
      r_data <= '0;
      r_last <= 1'b0;
      r_tmo  <= 1'b0;
    end else if (cke_i) begin
      case (r_state)
        S_IDLE: if (w_next == S_CLEAR) begin
          r_cnt <= '0;
          r_arm <= '0;
          r_idx <= '0;
          r_sel <= '0;
          r_tmo <= 1'b0;
        end
        S_CLEAR: r_cnt <= (w_next == S_ARM) ? '0 : r_cnt + 32'd1;
        S_ARM: begin
          r_arm <= r_arm + 32'd1;
          if ((w_next == S_READ) || (w_next == S_DONE)) begin
            r_ns  <= ila_samples_i;
            r_tmo <= !w_smp_hit;   // sample conditions take precedence
            r_cnt <= '0;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 32'd1;
          if (w_next == S_PUSH) begin
            r_data <= ila_value_i;
            r_last <= w_word_last;
          end
        end
        S_PUSH: if (w_next == S_READ) begin
          r_cnt <= '0;
          if (r_sel == SEL_LAST) begin
            r_sel <= '0;
            r_idx <= r_idx + BUFFER_W'(1);
          end else begin
            r_sel <= r_sel + SEL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Pass-through misc bits are forced low while reset is held.
  assign ila_misc_o  = arst_n_i ? {26'd0, cfg_misc_i[5:3], 1'b0, cfg_misc_i[1], (r_state == S_CLEAR)}
                                : 32'd0;
  assign ila_index_o = r_idx;
  assign ila_sel_o   = r_sel;
  assign m_valid_o   = (r_state == S_PUSH);
  assign m_data_o    = r_data;
  assign m_last_o    = r_last && (r_state == S_PUSH);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign timeout_o   = r_tmo;
  assign nsamples_o  = r_ns;

  logic w_unused;
  assign w_unused = ^{cfg_misc_i[31:6], cfg_misc_i[2], cfg_misc_i[0]};

endmodule

// File: tb/tb_ila_capture_seq.sv
// tb_ila_capture_seq: directed + randomized runs against a sample-counting ILA
// model; expected exit cycle, sample count, timeout flag and word stream are
// derived from the run parameters.
module tb_ila_capture_seq;
  localparam int DW = 16, BW = 4, NP = 2, SW = 1, RL = 2, CC = 4;
  localparam int INF = 1 << 30;

  logic          clk = 0, arst_n_i = 0, cke_i = 1, start_i = 0, abort_i = 0, m_ready_i = 1;
  logic [31:0]   cfg_misc_i = 0, timeout_i = 0;
  logic [BW-1:0] target_i = 0, ila_samples_i, ila_index_o, nsamples_o;
  logic [31:0]   ila_misc_o;
  logic [SW-1:0] ila_sel_o;
  logic [DW-1:0] ila_value_i, m_data_o;
  logic          m_valid_o, m_last_o, busy_o, done_o, timeout_o;

  ila_capture_seq #(.DATA_W(DW), .BUFFER_W(BW), .N_PARTS(NP), .SEL_W(SW),
                    .RD_LAT(RL), .CLR_CYC(CC)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .cke_i(cke_i), .start_i(start_i), .abort_i(abort_i),
    .cfg_misc_i(cfg_misc_i), .target_i(target_i), .timeout_i(timeout_i),
    .ila_misc_o(ila_misc_o), .ila_samples_i(ila_samples_i), .ila_index_o(ila_index_o),
    .ila_sel_o(ila_sel_o), .ila_value_i(ila_value_i), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o), .busy_o(busy_o),
    .done_o(done_o), .timeout_o(timeout_o), .nsamples_o(nsamples_o));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ILA model: soft clear zeroes the count, writer adds one sample per enabled
  // cycle up to full; read data comes through an RL-deep register pipe.
  logic [DW-1:0] mem [16][NP];
  logic [DW-1:0] pipe [RL];
  logic [BW-1:0] smp = 0;
  bit            wr_en = 0;
  assign ila_samples_i = smp;
  assign ila_value_i   = pipe[RL-1];
  always @(posedge clk) if (cke_i) begin
    if (ila_misc_o[0]) smp <= 0;
    else if (wr_en && smp != 4'hF) smp <= smp + 1;
    pipe[0] <= mem[ila_index_o][ila_sel_o];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end

  // ready / clock-enable driver
  int rdy_mode = 0;
  bit cke_rand = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = ~m_ready_i;
      default: m_ready_i = 1'($urandom_range(0, 1));
    endcase
    cke_i = cke_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // monitor (between edges, enabled cycles only)
  logic [DW-1:0] obs_d[$];
  bit            obs_l[$];
  int            n_clr, n_busy, n_done;
  bit            stalled, held_l;
  logic [DW-1:0] held_d;
  always @(negedge clk) if (arst_n_i && cke_i) begin
    chk("misc_bits", ila_misc_o & 32'hFFFF_FFFE,
        {26'd0, cfg_misc_i[5:3], 1'b0, cfg_misc_i[1], 1'b0});
    if (ila_misc_o[0]) n_clr++;
    if (busy_o) n_busy++;
    if (done_o) n_done++;
    if (m_valid_o) begin
      if (stalled) begin
        chk("stall_data", m_data_o, held_d);
        chk("stall_last", m_last_o, held_l);
      end
      if (m_ready_i && !abort_i) begin
        obs_d.push_back(m_data_o); obs_l.push_back(m_last_o); stalled = 0;
      end else begin
        stalled = !abort_i; held_d = m_data_o; held_l = m_last_o;
      end
    end else stalled = 0;
  end

  int ens, ek;
  bit etmo;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setup(input int tgt, input int tmo, input bit wr, input int rm, input bit cr);
    int ks, kt;
    for (int i = 0; i < 16; i++) for (int s = 0; s < NP; s++) mem[i][s] = DW'($urandom);
    target_i = BW'(tgt); timeout_i = tmo; wr_en = wr; rdy_mode = rm; cke_rand = cr;
    cfg_misc_i = $urandom;
    obs_d.delete(); obs_l.delete();
    n_clr = 0; n_busy = 0; n_done = 0; stalled = 0;
    // ARM cycle k sees k-1 samples; full buffer is 15 samples (cycle 16)
    ks = !wr ? INF : (tgt != 0 ? tgt + 1 : 16);
    kt = (tmo != 0) ? tmo : INF;
    ek = (ks <= kt) ? ks : kt;
    ens = wr ? ek - 1 : 0;
    etmo = (kt < ks);
  endtask

  task automatic pulse_start();
    bit c;
    start_i = 1;
    do begin @(posedge clk); c = cke_i; #1; end while (!c);
    start_i = 0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (busy_o && cyc < 4000) begin tick(1); cyc++; end
    chk({tag, "_finished"}, busy_o, 0);
    tick(1);
  endtask

  task automatic check_run(input string tag);
    int nw = ens * NP;
    chk({tag, "_clear_cycles"}, n_clr, CC);
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_nsamples"}, nsamples_o, ens);
    chk({tag, "_timeout"}, timeout_o, etmo);
    chk({tag, "_nwords"}, obs_d.size(), nw);
    if (ens == 0) chk({tag, "_busy_cycles"}, n_busy, CC + ek + 1);
    for (int j = 0; j < obs_d.size() && j < nw; j++) begin
      chk($sformatf("%s_word%0d", tag, j), obs_d[j], mem[j/NP][j%NP]);
      chk($sformatf("%s_last%0d", tag, j), obs_l[j], (j == nw - 1));
    end
  endtask

  task automatic full_run(input string tag, input int tgt, input int tmo, input bit wr,
                          input int rm, input bit cr);
    setup(tgt, tmo, wr, rm, cr);
    pulse_start();
    wait_done(tag);
    check_run(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_misc"}, ila_misc_o, 0);
    chk({tag, "_index"}, ila_index_o, 0);
    chk({tag, "_sel"}, ila_sel_o, 0);
    chk({tag, "_valid"}, m_valid_o, 0);
    chk({tag, "_data"}, m_data_o, 0);
    chk({tag, "_last"}, m_last_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_tmo"}, timeout_o, 0);
    chk({tag, "_nsamples"}, nsamples_o, 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < RL; i++) pipe[i] = 0;
    cfg_misc_i = 32'hFFFF_FFFF;
    tick(3);
    chk_zero("reset");
    arst_n_i = 1;
    tick(2);
    chk("idle_busy", busy_o, 0);

    full_run("target3",   3,   0, 1, 0, 0);
    full_run("toggle2",   2,   0, 1, 1, 0);
    full_run("timeout100", 0, 100, 0, 0, 0);
    full_run("full15",    0,   0, 1, 0, 0);
    full_run("tmo_part",  12, 10, 1, 2, 0);
    full_run("tie",       5,   6, 1, 0, 0);
    for (int r = 0; r < 3; r++)
      full_run($sformatf("rand%0d", r), $urandom_range(1, 15), $urandom_range(0, 20), 1, 2, 1);

    // second start while busy must not restart the run
    setup(3, 0, 1, 0, 0);
    pulse_start();
    tick(6);
    pulse_start();
    wait_done("restart");
    check_run("restart");

    // abort on the first PUSH together with ready
    setup(2, 0, 1, 0, 0);
    pulse_start();
    cyc = 0;
    while (!m_valid_o && cyc < 200) begin tick(1); cyc++; end
    chk("abort_reach_push", m_valid_o, 1);
    abort_i = 1;
    tick(1);
    abort_i = 0;
    chk("abort_busy", busy_o, 0);
    chk("abort_valid", m_valid_o, 0);
    tick(2);
    chk("abort_words", obs_d.size(), 0);
    chk("abort_done", n_done, 0);
    full_run("after_abort", 3, 0, 1, 0, 0);

    // reset asserted in READ
    setup(3, 0, 1, 0, 0);
    pulse_start();
    cyc = 0;
    while (!m_valid_o && cyc < 200) begin tick(1); cyc++; end
    chk("rst_reach_push", m_valid_o, 1);
    tick(1);
    arst_n_i = 0;
    #1;
    chk_zero("midrst");
    tick(2);
    arst_n_i = 1;
    tick(3);
    chk("midrst_idle", busy_o, 0);
    chk("midrst_done", n_done, 0);
    full_run("after_rst", 4, 0, 1, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
